// File: rtl/cntr_tmr_pkg.sv
// cntr_tmr_pkg: shared state encoding and default widths for the TMR down-counter family.
// Revision: 1.0
`default_nettype none

package cntr_tmr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int N_DEF = 16;
  localparam int M_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } tmr_state_e;

endpackage

`default_nettype wire

// File: rtl/cntr_nbit_sat.sv
// cntr_nbit_sat: M-bit saturating incrementer with synchronous clear and async active-low reset.
// Revision: 1.0
`default_nettype none

module cntr_nbit_sat
  import cntr_tmr_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [M-1:0] cnt_o
);

  logic [M-1:0] cnt_q;
  logic [M-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {M{1'b1}})) begin
      cnt_d = cnt_q + M'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/cntr_nbit_dwn_tmr.sv
// cntr_nbit_dwn_tmr: loadable N-bit down-counter/timer, one-shot or auto-reload, with underflow flag.
// Revision: 1.0
`default_nettype none

module cntr_nbit_dwn_tmr
  import cntr_tmr_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic         dec_i,
  input  logic         reload_mode_i,
  output logic [N-1:0] cnt_o,
  output logic         undrflw_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [M-1:0] undrflw_cnt_o
);

  tmr_state_e   state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] reload_q, reload_d;
  logic         undrflw_q, undrflw_d;
  logic         evt_clr, evt_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reload_d  = reload_q;
    undrflw_d = 1'b0;
    evt_clr   = 1'b0;
    evt_inc   = 1'b0;

    if (load_i) begin
      reload_d = load_val_i;
      cnt_d    = load_val_i;
      evt_clr  = 1'b1;
      if (state_q != S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (stop_i) begin
      // stop outranks start even where it has nothing to pause
      if (state_q == S_RUN) begin
        state_d = S_IDLE;
      end
    end else if (start_i && (state_q != S_RUN)) begin
      state_d = S_RUN;
      if (state_q == S_DONE) begin
        cnt_d = reload_q;
      end
    end else if ((state_q == S_RUN) && dec_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - N'(1);
      end else begin
        undrflw_d = 1'b1;
        evt_inc   = 1'b1;
        if (reload_mode_i) begin
          cnt_d = reload_q;
        end else begin
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      reload_q  <= '0;
      undrflw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      undrflw_q <= undrflw_d;
    end
  end

  cntr_nbit_sat #(
    .M (M)
  ) u_evt_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (evt_clr),
    .inc_i   (evt_inc),
    .cnt_o   (undrflw_cnt_o)
  );

  assign cnt_o     = cnt_q;
  assign undrflw_o = undrflw_q;
  assign busy_o    = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cntr_nbit_dwn_tmr.sv
// tb_cntr_nbit_dwn_tmr: randomized bench with a behavioural timer model plus directed literal checks.
// Revision: 1.0
`default_nettype none

module tb_cntr_nbit_dwn_tmr;

  localparam int N = 16;
  localparam int M = 8;
  localparam int UMAX = (1 << M) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load, start, stop, dec, mode;
  logic [N-1:0] load_val;
  logic [N-1:0] cnt;
  logic         undrflw, busy, done;
  logic [M-1:0] ucnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // behavioural model: what the outputs must be after the next edge
  int m_cnt, m_reload, m_ucnt;
  bit m_running, m_expired, m_uf;

  always #5 clk = ~clk;

  cntr_nbit_dwn_tmr #(.N(N), .M(M)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .load_i        (load),
    .load_val_i    (load_val),
    .start_i       (start),
    .stop_i        (stop),
    .dec_i         (dec),
    .reload_mode_i (mode),
    .cnt_o         (cnt),
    .undrflw_o     (undrflw),
    .busy_o        (busy),
    .done_o        (done),
    .undrflw_cnt_o (ucnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_reload = 0; m_ucnt = 0;
    m_running = 1'b0; m_expired = 1'b0; m_uf = 1'b0;
  endtask

  task automatic model_step();
    if (load) begin
      m_reload = int'(load_val);
      m_cnt    = int'(load_val);
      m_ucnt   = 0;
      m_uf     = 1'b0;
      if (!m_running) m_expired = 1'b0;
    end else if (stop) begin
      m_uf = 1'b0;
      m_running = 1'b0;
    end else if (start && !m_running) begin
      m_uf = 1'b0;
      if (m_expired) m_cnt = m_reload;
      m_expired = 1'b0;
      m_running = 1'b1;
    end else if (m_running && dec) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        m_uf  = 1'b0;
      end else begin
        m_uf   = 1'b1;
        m_ucnt = (m_ucnt < UMAX) ? m_ucnt + 1 : UMAX;
        if (mode) m_cnt = m_reload;
        else begin
          m_running = 1'b0;
          m_expired = 1'b1;
        end
      end
    end else begin
      m_uf = 1'b0;
    end
  endtask

  task automatic cyc(input bit ld, input int v, input bit st, input bit sp, input bit dc, input bit md);
    @(negedge clk);
    load = ld; load_val = N'(v); start = st; stop = sp; dec = dc; mode = md;
    model_step();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    load = 0; start = 0; stop = 0; dec = 0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_cnt", 32'(cnt), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_undrflw", 32'(undrflw), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_ucnt", 32'(ucnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("cnt", 32'(cnt), 32'(m_cnt));
      chk("undrflw", 32'(undrflw), 32'(m_uf));
      chk("busy", 32'(busy), 32'(m_running));
      chk("done", 32'(done), 32'(m_expired));
      chk("ucnt", 32'(ucnt), 32'(m_ucnt));
    end
  end

  initial begin
    rst_n = 1'b1;
    load = 0; load_val = '0; start = 0; stop = 0; dec = 0; mode = 0;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("reset_cnt", 32'(cnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_ucnt", 32'(ucnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // one-shot from 3 with dec held high
    cyc(1, 3, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    settle();
    chk("oneshot_undrflw", 32'(undrflw), 1);
    chk("oneshot_done", 32'(done), 1);
    chk("oneshot_busy", 32'(busy), 0);
    chk("oneshot_cnt", 32'(cnt), 0);
    chk("oneshot_ucnt", 32'(ucnt), 1);
    cyc(0, 0, 0, 0, 1, 0);
    settle();
    chk("oneshot_pulse_single", 32'(undrflw), 0);

    // auto-reload from 2, nine ticks
    cyc(1, 2, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0, 1);
    repeat (9) cyc(0, 0, 0, 0, 1, 1);
    settle();
    chk("auto_ucnt", 32'(ucnt), 3);
    chk("auto_cnt", 32'(cnt), 2);
    chk("auto_busy", 32'(busy), 1);

    // stop beats start, then resume from held count
    cyc(1, 5, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 0);
    settle();
    chk("stop_busy", 32'(busy), 0);
    chk("stop_cnt", 32'(cnt), 5);
    cyc(0, 0, 1, 0, 0, 0);
    settle();
    chk("resume_cnt", 32'(cnt), 5);
    chk("resume_busy", 32'(busy), 1);
    cyc(0, 0, 0, 0, 1, 0);
    settle();
    chk("resume_dec", 32'(cnt), 4);

    // load during RUN wins over the decrement
    cyc(1, 32'h00FF, 0, 0, 1, 0);
    settle();
    chk("load_run_cnt", 32'(cnt), 32'h00FF);
    chk("load_run_busy", 32'(busy), 1);
    chk("load_run_ucnt", 32'(ucnt), 0);

    // divide-by-1 with saturation of the event counter
    cyc(1, 0, 0, 0, 0, 1);
    settle();
    cyc(0, 0, 1, 0, 0, 1);
    repeat (UMAX + 6) cyc(0, 0, 0, 0, 1, 1);
    settle();
    chk("sat_ucnt", 32'(ucnt), UMAX);
    chk("sat_undrflw", 32'(undrflw), 1);

    // async reset mid-count at 7
    cyc(1, 7, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    settle();
    chk("pre_rst_cnt", 32'(cnt), 7);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 19) == 0,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 6)),
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 14) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1);
      end
    end

    settle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
